// File: rtl/stall_replay_buffer_pkg.sv
// Shared sizing helpers and the FIFO operation encoding for the stall replay buffer.
// Widths are derived from DEPTH so non-power-of-two depths size correctly.
package stall_buf_pkg;

   localparam int unsigned DEF_WIDTH = 32'd32;
   localparam int unsigned DEF_DEPTH = 32'd2;

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth + 32'd1);
   endfunction

   function automatic int unsigned ptr_width(input int unsigned depth);
      if (depth > 32'd1) begin
         return $clog2(depth);
      end else begin
         return 32'd1;
      end
   endfunction

   localparam int unsigned DEF_PTR_W = ptr_width(DEF_DEPTH);

endpackage

// File: rtl/stall_replay_buffer_if.sv
// Source/consumer side bundle of the stall replay buffer; the buffer uses the slave view.
interface stall_replay_buffer_if #(
   parameter int unsigned WIDTH = stall_buf_pkg::DEF_WIDTH,
   parameter int unsigned DEPTH = stall_buf_pkg::DEF_DEPTH
) ();

   localparam int unsigned CNT_W = stall_buf_pkg::count_width(DEPTH);

   logic             stall;
   logic [WIDTH-1:0] in;
   logic             in_valid;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             hold;
   logic [CNT_W-1:0] count;
   logic             overflow;

   modport master (
      output stall, in, in_valid,
      input  out, out_valid, hold, count, overflow
   );

   modport slave (
      input  stall, in, in_valid,
      output out, out_valid, hold, count, overflow
   );

endinterface

// File: rtl/stall_replay_buffer_chk.sv
// Runtime properties of the replay buffer: bounded occupancy, stall stability, sticky overflow.
module stall_replay_buffer_chk #(
   parameter int unsigned WIDTH = 32'd32,
   parameter int unsigned DEPTH = 32'd2,
   parameter int unsigned CNT_W = 32'd2
) (
   input logic             clk,
   input logic             reset_n,
   input logic             stall,
   input logic [WIDTH-1:0] out,
   input logic             out_valid,
   input logic [CNT_W-1:0] count,
   input logic             overflow
);

   a_count_range: assert property (@(posedge clk) disable iff (!reset_n)
      count <= CNT_W'(DEPTH));

   // A beat shown while stalled must still be shown, unchanged, next cycle.
   a_stall_stable: assert property (@(posedge clk) disable iff (!reset_n)
      (stall && out_valid) |=> (out_valid && $stable(out)));

   a_overflow_sticky: assert property (@(posedge clk) disable iff (!reset_n)
      overflow |=> overflow);

endmodule

// File: rtl/stall_replay_buffer_fifo.sv
// WIDTH x DEPTH register FIFO with explicitly wrapping pointers and an occupancy count.
// The caller guarantees no push into a full FIFO without a pop, and no pop when empty.
module stall_buf_fifo
   import stall_buf_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          i_push,
   input  logic                          i_pop,
   input  logic [WIDTH-1:0]              i_data,
   output logic [WIDTH-1:0]              o_head,
   output logic [count_width(DEPTH)-1:0] o_count
);

   localparam int unsigned PTR_W = ptr_width(DEPTH);
   localparam int unsigned CNT_W = count_width(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   fifo_op_e         w_op;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(DEPTH - 32'd1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return ptr + PTR_W'(1);
      end
   endfunction

   assign w_op    = fifo_op_e'({i_push, i_pop});
   assign o_head  = r_mem[r_head];
   assign o_count = r_count;

   // Storage is deliberately left unreset; only occupied slots are ever read.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_tail] <= i_data;
      end
   end

   // Pointer and occupancy state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_head  <= {PTR_W{1'b0}};
         r_tail  <= {PTR_W{1'b0}};
         r_count <= {CNT_W{1'b0}};
      end else begin
         if (i_push) begin
            r_tail <= next_ptr(r_tail);
         end
         if (i_pop) begin
            r_head <= next_ptr(r_head);
         end
         case (w_op)
            OP_PUSH: r_count <= r_count + CNT_W'(1);
            OP_POP:  r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/stall_replay_buffer.sv
// Lossless skid/replay buffer between a fixed-latency source and a stallable consumer.
// Empty: zero-latency bypass of the source; otherwise the oldest stored beat is presented.
module stall_replay_buffer
   import stall_buf_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input logic                  clk,
   input logic                  reset_n,
   stall_replay_buffer_if.slave bus
);

   localparam int unsigned CNT_W = count_width(DEPTH);

   logic [WIDTH-1:0] w_head;
   logic [CNT_W-1:0] w_count;
   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_push_req;
   logic             w_push;
   logic             w_drop;
   logic             r_overflow;

   assign w_empty = (w_count == {CNT_W{1'b0}});
   assign w_full  = (w_count == CNT_W'(DEPTH));

   // A bypassed beat taken by the consumer is never stored; any other arrival queues behind the head.
   assign w_pop      = ~w_empty & ~bus.stall;
   assign w_push_req = bus.in_valid & ~(w_empty & ~bus.stall);
   assign w_push     = w_push_req & (~w_full | w_pop);
   assign w_drop     = w_push_req & w_full & ~w_pop;

   assign bus.out       = w_empty ? bus.in : w_head;
   assign bus.out_valid = reset_n & (w_empty ? bus.in_valid : 1'b1);
   assign bus.hold      = bus.stall | ~w_empty;
   assign bus.count     = w_count;
   assign bus.overflow  = r_overflow;

   stall_buf_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (bus.in),
      .o_head  (w_head),
      .o_count (w_count)
   );

   // Sticky record of any beat lost to a full buffer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else begin
         r_overflow <= r_overflow;
      end
   end

   stall_replay_buffer_chk #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_chk (
      .clk       (clk),
      .reset_n   (reset_n),
      .stall     (bus.stall),
      .out       (bus.out),
      .out_valid (bus.out_valid),
      .count     (w_count),
      .overflow  (r_overflow)
   );

endmodule

// File: tb/tb_stall_replay_buffer.sv
// Bench for stall_replay_buffer: queue-based reference checked every cycle plus directed literal checks.
module tb_stall_replay_buffer;

   localparam int unsigned W = 32;
   localparam int unsigned D = 2;

   logic clk;
   logic reset_n;
   logic cmp_en;

   stall_replay_buffer_if #(.WIDTH(W), .DEPTH(D)) bus ();

   stall_replay_buffer #(.WIDTH(W), .DEPTH(D)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [W-1:0] m_q[$];
   logic         m_ovf;
   logic [W-1:0] seen[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: a FIFO of beats the consumer has not yet taken.
   always @(negedge reset_n) begin
      m_q.delete();
      m_ovf <= 1'b0;
   end

   always @(posedge clk) begin
      if (reset_n && cmp_en) begin
         automatic int  sz     = m_q.size();
         automatic bit  taken  = (sz == 0) && bus.in_valid && !bus.stall;
         automatic bit  popped = (sz != 0) && !bus.stall;
         if (popped) void'(m_q.pop_front());
         if (bus.in_valid && !taken) begin
            if (sz < int'(D) || popped) m_q.push_back(bus.in);
            else m_ovf <= 1'b1;
         end
      end
   end

   // Per-cycle comparison against the reference, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         if (!reset_n) begin
            chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
            chk("rst_count", {30'd0, bus.count}, 32'd0);
            chk("rst_hold", {31'd0, bus.hold}, {31'd0, bus.stall});
         end else begin
            automatic int         sz = m_q.size();
            automatic logic       ev = (sz != 0) ? 1'b1 : bus.in_valid;
            automatic logic [W-1:0] eo = (sz != 0) ? m_q[0] : bus.in;
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, ev});
            if (ev) chk("out", bus.out, eo);
            chk("count", {30'd0, bus.count}, sz);
            chk("hold", {31'd0, bus.hold}, {31'd0, bus.stall || (sz != 0)});
            chk("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
            if (bus.out_valid && !bus.stall) seen.push_back(bus.out);
         end
      end
   end

   task automatic set_in(input logic st, input logic iv, input logic [W-1:0] d);
      @(posedge clk);
      #1;
      bus.stall    = st;
      bus.in_valid = iv;
      bus.in       = d;
      @(negedge clk);
      #1;
   endtask

   task automatic lit(input string nm, input logic [W-1:0] o, input logic ov, input int c, input logic h);
      chk({nm, "_valid"}, {31'd0, bus.out_valid}, {31'd0, ov});
      if (ov) chk({nm, "_out"}, bus.out, o);
      chk({nm, "_count"}, {30'd0, bus.count}, c);
      chk({nm, "_hold"}, {31'd0, bus.hold}, {31'd0, h});
   endtask

   initial begin
      cmp_en       = 1'b0;
      m_ovf        = 1'b0;
      reset_n      = 1'b1;
      bus.stall    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in       = '0;
      #1 reset_n = 1'b0;
      #2;
      chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("reset_count", {30'd0, bus.count}, 32'd0);
      chk("reset_overflow", {31'd0, bus.overflow}, 32'd0);
      bus.stall = 1'b1;
      #1;
      chk("reset_hold_follows_stall", {31'd0, bus.hold}, 32'd1);
      bus.stall = 1'b0;
      cmp_en = 1'b1;
      @(negedge clk);
      #2 reset_n = 1'b1;

      // Bypass
      set_in(1'b0, 1'b1, 32'hA); lit("byp_a", 32'hA, 1'b1, 0, 1'b0);
      set_in(1'b0, 1'b1, 32'hB); lit("byp_b", 32'hB, 1'b1, 0, 1'b0);

      // Stall hold of a bypassed beat
      set_in(1'b1, 1'b1, 32'h11); lit("sh0", 32'h11, 1'b1, 0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 1'b0, 32'h0); lit("sh_stall", 32'h11, 1'b1, 1, 1'b1);
      end
      set_in(1'b0, 1'b0, 32'h0); lit("sh_release", 32'h11, 1'b1, 1, 1'b1);
      set_in(1'b0, 1'b0, 32'h0); lit("sh_empty", 32'h0, 1'b0, 0, 1'b0);

      // Skid and replay
      set_in(1'b1, 1'b1, 32'h1); lit("sk0", 32'h1, 1'b1, 0, 1'b1);
      set_in(1'b1, 1'b1, 32'h2); lit("sk1", 32'h1, 1'b1, 1, 1'b1);
      set_in(1'b1, 1'b0, 32'h0); lit("sk2", 32'h1, 1'b1, 2, 1'b1);
      set_in(1'b0, 1'b0, 32'h0); lit("sk_rep1", 32'h1, 1'b1, 2, 1'b1);
      set_in(1'b0, 1'b0, 32'h0); lit("sk_rep2", 32'h2, 1'b1, 1, 1'b1);
      set_in(1'b0, 1'b0, 32'h0); lit("sk_done", 32'h0, 1'b0, 0, 1'b0);

      // Full buffer with simultaneous push and pop
      set_in(1'b1, 1'b1, 32'h21);
      set_in(1'b1, 1'b1, 32'h22);
      set_in(1'b0, 1'b1, 32'h9);  lit("fp0", 32'h21, 1'b1, 2, 1'b1);
      set_in(1'b0, 1'b0, 32'h0);  lit("fp1", 32'h22, 1'b1, 2, 1'b1);
      chk("fp_no_overflow", {31'd0, bus.overflow}, 32'd0);
      set_in(1'b0, 1'b0, 32'h0);  lit("fp2", 32'h9, 1'b1, 1, 1'b1);
      set_in(1'b0, 1'b0, 32'h0);  lit("fp3", 32'h0, 1'b0, 0, 1'b0);

      // Overflow
      seen.delete();
      set_in(1'b1, 1'b1, 32'h5);
      set_in(1'b1, 1'b1, 32'h6);
      set_in(1'b1, 1'b1, 32'h7); lit("ov_third", 32'h5, 1'b1, 2, 1'b1);
      chk("ov_not_yet", {31'd0, bus.overflow}, 32'd0);
      set_in(1'b1, 1'b0, 32'h0); lit("ov_after", 32'h5, 1'b1, 2, 1'b1);
      chk("ov_set", {31'd0, bus.overflow}, 32'd1);
      for (int i = 0; i < 3; i++) set_in(1'b0, 1'b0, 32'h0);
      chk("ov_seen_len", seen.size(), 32'd2);
      if (seen.size() == 2) begin
         chk("ov_seen0", seen[0], 32'h5);
         chk("ov_seen1", seen[1], 32'h6);
      end
      chk("ov_sticky", {31'd0, bus.overflow}, 32'd1);

      // Asynchronous reset mid-replay
      set_in(1'b1, 1'b1, 32'h31);
      set_in(1'b1, 1'b1, 32'h32);
      set_in(1'b0, 1'b0, 32'h0); lit("ar_replay", 32'h31, 1'b1, 2, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      chk("ar_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("ar_count", {30'd0, bus.count}, 32'd0);
      chk("ar_overflow", {31'd0, bus.overflow}, 32'd0);
      @(posedge clk);
      #2 reset_n = 1'b1;
      set_in(1'b0, 1'b1, 32'h3); lit("ar_bypass", 32'h3, 1'b1, 0, 1'b0);

      // Mixed traffic, checked by the reference every cycle
      for (int i = 0; i < 60; i++) begin
         set_in(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0), $urandom);
      end
      for (int i = 0; i < 3; i++) set_in(1'b0, 1'b0, 32'h0);
      lit("drained", 32'h0, 1'b0, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/stall_replay_buffer.md
# stall_replay_buffer

- Parametrised buffer between a fixed-latency data source (BRAM read port, instruction/data memory output) and a pipeline stage that can stall.
- Such a source keeps delivering data after the pipeline stalls. This block stores every valid beat that arrives while the consumer is stalled, or while older data is still queued.
- It replays the stored beats in order once the stall clears. The pipeline therefore sees a stable, lossless stream.
- It generalises single-entry hold logic to WIDTH bits, DEPTH entries, per-beat valid, a hold request to the source, and overflow detection.

## Interface
- WIDTH, 32: data width in bits.
- DEPTH, 2: number of buffer entries, ≥1; need not be a power of two.
- clk  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- stall  input  1  consumer cannot accept `out` this cycle.
- in  input  WIDTH  source data.
- in_valid  input  1  `in` carries a beat this cycle; the source does not react to backpressure within the cycle.
- out  output  WIDTH  data presented to the consumer.
- out_valid  output  1  `out` carries a beat.
- hold  output  1  request to the source to stop issuing new reads.
- count  output  $clog2(DEPTH+1)  number of occupied entries.
- overflow  output  1  sticky; a beat was dropped.

## Operation
- Consumption rule: a beat is consumed on any cycle where out_valid=1 and stall=0.
- Empty buffer (count=0):
  - out = in, out_valid = in_valid; this is a combinational bypass with zero latency.
  - If in_valid and !stall, the beat is consumed and not stored.
  - If in_valid and stall, the beat is shown on `out` and also pushed.
- Non-empty buffer:
  - out = head entry, out_valid = 1.
  - The head is popped when !stall.
  - in_valid pushes to the tail, whatever the value of stall. Order is strictly FIFO.
- Simultaneous push and pop:
  - Both happen and count is unchanged.
  - This applies even when count = DEPTH, because the pop frees a slot in the same cycle.
- Push with count = DEPTH and no pop:
  - The beat is dropped and the buffer contents are unchanged.
  - overflow is set to 1 and stays set until reset.
- hold = stall | (count != 0). It is combinational from the `stall` input and registered count.
- Pointers: head and tail each wrap from DEPTH-1 to 0 explicitly; no power-of-two masking.
- count is registered: +1 on push-only, -1 on pop-only, unchanged otherwise.
- The storage array is not reset. Its contents are meaningless when count=0.

## Timing
- Reset (reset_n low, asynchronous):
  - count=0, head=tail=0, overflow=0.
  - out_valid forced 0 while reset_n is low; `out` is don't-care during reset.
  - hold follows `stall` during reset.
- Bypass latency is 0 cycles.
- Replay: after the stall falls, one stored beat is presented per cycle, starting in the first cycle with stall=0.
- Drain time is count cycles plus any stall cycles in between. hold deasserts in the cycle after the final pop.
- Stall onset: the beat visible on the first stall cycle stays on `out` unchanged through every following stall cycle. This holds whether the beat came from the bypass or from the head.
- Reset asserted mid-replay discards all queued beats immediately. After release, the block starts empty in bypass.

## Structure
- Package stall_buf_pkg:
  - function for the count width: $clog2(DEPTH+1).
  - localparam for the pointer width: max(1, $clog2(DEPTH)).
- One sub-module, stall_buf_fifo: a WIDTH×DEPTH register array with push/pop, head/tail pointers and count.
- The top level holds the bypass mux, the consume/push decode, hold and overflow.

## Test plan
- Bypass: DEPTH=2, stall=0, in_valid=1, in=0xA, then 0xB.
  - Required: out=0xA then 0xB, each in the same cycle as its input.
  - Required: count stays 0 and hold=0 throughout.
- Stall hold: in=0x11 valid with stall rising, then in_valid=0 for 3 stall cycles.
  - Required: out=0x11, out_valid=1 for all 4 cycles, and count=1.
  - Required: the beat is consumed in the first cycle with stall=0, and count returns to 0.
- Skid and replay: stall for 3 cycles while 0x1, 0x2 arrive valid on the first two, then stall drops.
  - Required: out stays 0x1 during the stall; then 0x1 and 0x2 on consecutive cycles.
  - Required: hold=1 until count returns to 0.
- Overflow: DEPTH=2, stall held, 3 valid beats 0x5, 0x6, 0x7.
  - Required: count=2 and overflow=1 after the third beat.
  - Required: the replay is 0x5 then 0x6, and 0x7 is never seen.
- Full push+pop: count=2, stall=0, in_valid=1 with in=0x9.
  - Required: the head is consumed, 0x9 is enqueued, count stays 2, and overflow stays 0.
- Async reset mid-replay: count=2, drop reset_n between clock edges.
  - Required: out_valid=0 and count=0 immediately, with no clock edge needed.
  - Required: after release, in=0x3 valid bypasses to out in the same cycle.
